prog_rom_monitor: RTL

- Parametrised program ROM and run monitor for the mips_cpu_harvard instruction port. It is loadable at runtime, supports 0 or 1 cycle read latency, and bounds each run with a cycle-count timeout.
- It serves instructions from a base address and detects the halt condition: a fetch from HALT_ADDR, or `active` falling.
- At halt it captures register_v0, compares it against an expected value, and reports pass/fail.
- It is instantiated once per CPU testbench and replaces hard-coded per-test instruction decoders.

---
 rtl/tb_pkg.sv | 26 ++
 rtl/prog_rom_monitor_array.sv | 74 +++++++
 rtl/prog_rom_monitor.sv | 113 +++++++++++
 3 files changed

// File: rtl/tb_pkg.sv
// ============================================================================
//  Module      : tb_pkg
//  Description : Shared types and constants for the program ROM run monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tb_pkg;

    // Run monitor states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } monitor_state_e;

    // Word returned for any fetch that misses the ROM window
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    // MIPS reset vector, the natural base of the program ROM
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage : tb_pkg

`default_nettype wire

// File: rtl/prog_rom_monitor_array.sv
// ============================================================================
//  Module      : prog_rom_array
//  Description : 2**DEPTH_LOG2 x 32 instruction store with one write port and
//                one byte-addressed read port. Misaligned or out-of-window
//                fetches return a NOP. Read is combinational or registered.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_rom_array
    import tb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = RESET_VECTOR,
    parameter int          DEPTH_LOG2   = 6,
    parameter int          READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_index,
    input  logic [31:0]           wr_data,
    input  logic [31:0]           rd_addr,
    output logic [31:0]           rd_data
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           offset;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] rd_index;
    logic [31:0]           rd_word;

    // ROM storage is deliberately not reset so a program survives a reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index] <= wr_data;
        end
    end

    // Window decode: wrapping offset, word aligned, upper index bits all zero
    always_comb begin
        offset   = rd_addr - BASE_ADDR;
        hit      = (offset[1:0] == 2'b00) && (offset[31:DEPTH_LOG2+2] == '0);
        rd_index = offset[DEPTH_LOG2+1:2];
        rd_word  = hit ? mem[rd_index] : NOP_WORD;
    end

    if (READ_LATENCY == 0) begin : g_comb_read
        logic unused_comb_inputs;
        assign unused_comb_inputs = clk_enable ^ reset;
        assign rd_data = rd_word;
    end else if (READ_LATENCY == 1) begin : g_reg_read
        logic [31:0] rd_q;

        // Registered read advances only on enabled cycles
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_q <= NOP_WORD;
            end else if (clk_enable) begin
                rd_q <= rd_word;
            end
        end

        assign rd_data = rd_q;
    end else begin : g_bad_latency
        $error("prog_rom_array: READ_LATENCY must be 0 or 1");
        assign rd_data = NOP_WORD;
    end

endmodule : prog_rom_array

`default_nettype wire

// File: rtl/prog_rom_monitor.sv
// ============================================================================
//  Module      : prog_rom_monitor
//  Description : Runtime-loadable program ROM for the CPU instruction port,
//                plus a run monitor that detects halt (fetch of HALT_ADDR or
//                active low), captures register_v0, grades it against
//                expected_v0 and bounds each run with a cycle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_rom_monitor
    import tb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = RESET_VECTOR,
    parameter int          DEPTH_LOG2     = 6,
    parameter int          READ_LATENCY   = 0,
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_index,
    input  logic [31:0]           load_data,
    input  logic                  start,
    input  logic [31:0]           expected_v0,
    input  logic [31:0]           instr_address,
    output logic [31:0]           instr_readdata,
    input  logic                  active,
    input  logic [31:0]           register_v0,
    output logic                  done,
    output logic                  pass,
    output logic                  timed_out,
    output logic [31:0]           captured_v0,
    output logic [31:0]           cycle_count
);

    localparam logic [31:0] LAST_COUNT = 32'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("prog_rom_monitor: TIMEOUT_CYCLES must be at least 2");
    end

    monitor_state_e state;
    logic           rom_wr_en;
    logic           halt_hit;

    // ROM is writable only while idle; reads are served in every state
    assign rom_wr_en = load_en && (state == IDLE);
    assign halt_hit  = (instr_address == HALT_ADDR) || !active;

    prog_rom_array #(
        .BASE_ADDR    (BASE_ADDR),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .READ_LATENCY (READ_LATENCY)
    ) u_rom (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .wr_en      (rom_wr_en),
        .wr_index   (load_index),
        .wr_data    (load_data),
        .rd_addr    (instr_address),
        .rd_data    (instr_readdata)
    );

    // Run monitor: halt beats timeout, results hold until the next start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            timed_out   <= 1'b0;
            captured_v0 <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                IDLE, DONE, TIMEOUT: begin
                    if (start) begin
                        state       <= RUN;
                        cycle_count <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timed_out   <= 1'b0;
                    end
                end
                RUN: begin
                    if (clk_enable) begin
                        if (halt_hit) begin
                            state       <= DONE;
                            captured_v0 <= register_v0;
                            pass        <= (register_v0 == expected_v0);
                            done        <= 1'b1;
                        end else if (cycle_count == LAST_COUNT) begin
                            state       <= TIMEOUT;
                            captured_v0 <= register_v0;
                            pass        <= 1'b0;
                            done        <= 1'b1;
                            timed_out   <= 1'b1;
                        end else begin
                            cycle_count <= cycle_count + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : prog_rom_monitor

`default_nettype wire
